// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor cell feeds a borrow flip-flop; the operands and
// the partial result live in shift registers. diff/borrow/ovf update only
// on entry to DONE, so partial results never appear on the outputs.
module serial_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic [N-1:0]  res;
    logic          bin;
    logic [CW-1:0] cnt;
    logic          msb_a;
    logic          msb_b;

    logic x;
    logic y;
    logic d;
    logic bout;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        x    = ra[0];
        y    = rb[0];
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            ra     <= '0;
            rb     <= '0;
            res    <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            msb_a  <= 1'b0;
            msb_b  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state <= StRun;
                        busy  <= 1'b1;
                        ra    <= a;
                        rb    <= b;
                        res   <= '0;
                        bin   <= 1'b0;
                        cnt   <= '0;
                        msb_a <= a[N-1];
                        msb_b <= b[N-1];
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    res <= {d, res[N-1:1]};
                    bin <= bout;
                    cnt <= cnt + CW'(1);
                    // Last bit: d is the result MSB, bout the final borrow.
                    if (cnt == LastCnt) begin
                        state  <= StDone;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        diff   <= {d, res[N-1:1]};
                        borrow <= bout;
                        ovf    <= (msb_a != msb_b) && (d != msb_a);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and randomised bench for serial_subtractor (N=8 and N=13).
// Cycle timing: cyc counts rising edges; t0 is the value of cyc just after
// the accepting edge, and done is expected to be visible when cyc == t0+N.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  diff;
    logic        borrow;
    logic        ovf;

    logic        start13;
    logic [12:0] a13;
    logic [12:0] b13;
    logic        busy13;
    logic        done13;
    logic [12:0] diff13;
    logic        borrow13;
    logic        ovf13;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    serial_subtractor #(.N(13)) dut13 (
        .clk    (clk),
        .rst    (rst),
        .start  (start13),
        .a      (a13),
        .b      (b13),
        .busy   (busy13),
        .done   (done13),
        .diff   (diff13),
        .borrow (borrow13),
        .ovf    (ovf13)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one N=8 operation from IDLE and wait (bounded) for done.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         output logic [7:0] rd, output logic rbr, output logic rov,
                         output int lat, output int busy_bad, output logic done_after);
        int t0;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        busy_bad = 0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
        end
        rd = diff; rbr = borrow; rov = ovf;
        if (busy !== 1'b0) busy_bad++;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo);
        logic [7:0] rd;
        logic rbr, rov, da;
        int lat, bb;
        do_op(ta, tb_v, rd, rbr, rov, lat, bb, da);
        check($sformatf("diff %0d-%0d", ta, tb_v), 32'(rd), 32'(ed));
        check($sformatf("borrow %0d-%0d", ta, tb_v), 32'(rbr), 32'(eb));
        check($sformatf("ovf %0d-%0d", ta, tb_v), 32'(rov), 32'(eo));
        check("latency", 32'(lat), 32'd8);
        check("busy window", 32'(bb), 32'd0);
        check("done single pulse", 32'(da), 32'd0);
    endtask

    task automatic run13(input logic [12:0] ta, input logic [12:0] tb_v);
        logic signed [13:0] sd;
        logic [12:0] ed;
        int t0, lat;
        logic rd_ok;
        ed = ta - tb_v;
        sd = $signed({ta[12], ta}) - $signed({tb_v[12], tb_v});
        @(negedge clk);
        a13 = ta; b13 = tb_v; start13 = 1'b1;
        @(negedge clk);
        start13 = 1'b0;
        t0 = cyc;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (done13) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check("n13 diff", 32'(diff13), 32'(ed));
        check("n13 borrow", 32'(borrow13), 32'(ta < tb_v));
        check("n13 ovf", 32'(ovf13), 32'(sd[13] != sd[12]));
        check("n13 latency", 32'(lat), 32'd13);
        @(negedge clk);
        rd_ok = done13;
        check("n13 done single pulse", 32'(rd_ok), 32'd0);
    endtask

    initial begin
        int t0, lat, hits;
        logic [7:0] ra8, rb8;
        logic signed [8:0] sd;

        vecs[0] = '{a: 8'd100,  b: 8'd58,   d: 8'd42,   br: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'd5,    b: 8'd10,   d: 8'd251,  br: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h80,   b: 8'h01,   d: 8'h7F,   br: 1'b0, ov: 1'b1};
        vecs[3] = '{a: 8'h7F,   b: 8'hFF,   d: 8'h80,   br: 1'b1, ov: 1'b1};
        vecs[4] = '{a: 8'h55,   b: 8'h55,   d: 8'h00,   br: 1'b0, ov: 1'b0};
        vecs[5] = '{a: 8'hC3,   b: 8'h00,   d: 8'hC3,   br: 1'b0, ov: 1'b0};
        vecs[6] = '{a: 8'h00,   b: 8'h01,   d: 8'hFF,   br: 1'b1, ov: 1'b0};
        vecs[7] = '{a: 8'hFF,   b: 8'h80,   d: 8'h7F,   br: 1'b0, ov: 1'b0};
        vecs[8] = '{a: 8'h80,   b: 8'h7F,   d: 8'h01,   br: 1'b0, ov: 1'b1};
        vecs[9] = '{a: 8'h00,   b: 8'h80,   d: 8'h80,   br: 1'b1, ov: 1'b1};

        // Reset, with start held high: reset must win.
        rst = 1'b1; start = 1'b1; a = 8'd7; b = 8'd3;
        start13 = 1'b0; a13 = '0; b13 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow", 32'(borrow), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov);

        // In-flight start ignored, then back-to-back start in the DONE cycle.
        @(negedge clk);
        a = 8'd200; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        a = 8'd0; b = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'd3; b = 8'd3;
        hits = 0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check("b2b first latency", 32'(lat), 32'd8);
        check("b2b first diff", 32'(diff), 32'd199);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy after DONE start", 32'(busy), 32'd1);
        check("b2b done cleared", 32'(done), 32'd0);
        check("b2b diff held", 32'(diff), 32'd199);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check("b2b second latency", 32'(lat), 32'd17);
        check("b2b second diff", 32'(diff), 32'd0);
        check("b2b second borrow", 32'(borrow), 32'd0);
        @(negedge clk);

        // Reset mid-RUN aborts the operation.
        run8(8'd100, 8'd58, 8'd42, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'd50; b = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) hits++;
            @(negedge clk);
        end
        check("abort no done", 32'(hits), 32'd0);
        run8(8'd9, 8'd4, 8'd5, 1'b0, 1'b0);

        // Randomised N=8 against an arithmetic reference.
        for (int i = 0; i < 300; i++) begin
            ra8 = 8'($urandom);
            rb8 = (i % 16 == 0) ? ra8 : 8'($urandom);
            sd = $signed({ra8[7], ra8}) - $signed({rb8[7], rb8});
            run8(ra8, rb8, ra8 - rb8, ra8 < rb8, sd[8] != sd[7]);
        end

        // Randomised N=13.
        for (int i = 0; i < 150; i++)
            run13(13'($urandom), 13'($urandom));
        run13(13'h1000, 13'h0001);
        run13(13'h0FFF, 13'h1FFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
